// File: rtl/iot_riscv_dbgctrl_if.sv
// Register access bus of the debug controller.
// Master drives strobe/address/data, slave returns registered read data.
interface iot_riscv_dbgctrl_if;
   logic        reg_en_i;
   logic        reg_wr_i;
   logic [2:0]  reg_addr_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] reg_rdata_o;

   modport master (
      output reg_en_i,
      output reg_wr_i,
      output reg_addr_i,
      output reg_wdata_i,
      input  reg_rdata_o
   );

   modport slave (
      input  reg_en_i,
      input  reg_wr_i,
      input  reg_addr_i,
      input  reg_wdata_i,
      output reg_rdata_o
   );
endinterface

// File: rtl/iot_riscv_dbgctrl.sv
// Debug controller: halt/step/resume FSM, HW breakpoints, sticky BRK flag.
// Optional halt-cycle counter enabled by IOT_RISCV_DBGCTRL_HALTCNT_EN.
module iot_riscv_dbgctrl (
   input  logic                      main_clk_i,
   input  logic                      main_rst_an_i,
   iot_riscv_dbgctrl_if.slave        reg_bus,
   output logic                      riscv_debug_pause_o,
   output logic                      riscv_debug_step_o,
   input  logic                      debug_halt_i,
   input  logic                      debug_halt_data_i,
   input  logic                      riscv_debug_break_i,
   output logic [30:0]               riscv_bp0_bp_addr_o,
   output logic                      riscv_bp0_bp_en_o,
   output logic [30:0]               riscv_bp1_bp_addr_o,
   output logic                      riscv_bp1_bp_en_o,
   output logic                      riscv_dbp0_dbp_en_o,
   output logic                      riscv_dbp0_dbp_wr_o,
   output logic [29:0]               riscv_dbp0_dbp_addr_o,
   output logic                      riscv_dbp1_dbp_en_o,
   output logic                      riscv_dbp1_dbp_wr_o,
   output logic [29:0]               riscv_dbp1_dbp_addr_o
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      PAUSING  = 3'd1,
      HALTED   = 3'd2,
      STEP     = 3'd3,
      STEPWAIT = 3'd4,
      RESUME   = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] bp0;
   logic [31:0] bp1;
   logic [31:0] dbp0;
   logic [31:0] dbp1;
   logic [31:0] haltcnt;
   logic [31:0] status;
   logic [31:0] rdata;
   logic [31:0] rdata_nxt;
   logic        brk;
   logic        wr_en;
   logic        rd_en;
   logic [3:0]  cmd;

   assign wr_en = reg_bus.reg_en_i & reg_bus.reg_wr_i;
   assign rd_en = reg_bus.reg_en_i & ~reg_bus.reg_wr_i;
   assign cmd   = (wr_en && reg_bus.reg_addr_i == 3'd0) ?
                  reg_bus.reg_wdata_i[3:0] : 4'd0;

   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) state <= RUN;
      else                state <= state_nxt;
   end

   // Only HALTED accepts two commands at once; RESUME beats STEP there.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (debug_halt_i | debug_halt_data_i) state_nxt = HALTED;
            else if (cmd[0])                      state_nxt = PAUSING;
         end
         PAUSING:  if (debug_halt_i) state_nxt = HALTED;
         HALTED: begin
            if (cmd[2])      state_nxt = RESUME;
            else if (cmd[1]) state_nxt = STEP;
         end
         STEP:     state_nxt = STEPWAIT;
         STEPWAIT: if (debug_halt_i) state_nxt = HALTED;
         RESUME:   state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   always_comb begin
      riscv_debug_pause_o = 1'b0;
      riscv_debug_step_o  = 1'b0;
      case (state)
         PAUSING, HALTED, STEPWAIT: riscv_debug_pause_o = 1'b1;
         STEP: begin
            riscv_debug_pause_o = 1'b1;
            riscv_debug_step_o  = 1'b1;
         end
         RESUME:  riscv_debug_step_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         bp0  <= '0;
         bp1  <= '0;
         dbp0 <= '0;
         dbp1 <= '0;
      end else if (wr_en) begin
         case (reg_bus.reg_addr_i)
            3'd2:    bp0  <= reg_bus.reg_wdata_i;
            3'd3:    bp1  <= reg_bus.reg_wdata_i;
            3'd4:    dbp0 <= reg_bus.reg_wdata_i;
            3'd5:    dbp1 <= reg_bus.reg_wdata_i;
            default: ;
         endcase
      end
   end

   // A break arriving with CLR_BRK must not be lost.
   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i)          brk <= 1'b0;
      else if (riscv_debug_break_i) brk <= 1'b1;
      else if (cmd[3])              brk <= 1'b0;
   end

`ifdef IOT_RISCV_DBGCTRL_HALTCNT_EN
   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i)
         haltcnt <= '0;
      else if (wr_en && reg_bus.reg_addr_i == 3'd6)
         haltcnt <= '0;
      else if (debug_halt_i && haltcnt != 32'hFFFF_FFFF)
         haltcnt <= haltcnt + 32'd1;
   end
`else
   assign haltcnt = '0;
`endif

   assign status = {26'd0, brk, debug_halt_data_i, debug_halt_i, state};

   always_comb begin
      rdata_nxt = '0;
      case (reg_bus.reg_addr_i)
         3'd1:    rdata_nxt = status;
         3'd2:    rdata_nxt = bp0;
         3'd3:    rdata_nxt = bp1;
         3'd4:    rdata_nxt = dbp0;
         3'd5:    rdata_nxt = dbp1;
         3'd6:    rdata_nxt = haltcnt;
         default: rdata_nxt = '0;
      endcase
   end

   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) rdata <= '0;
      else if (rd_en)     rdata <= rdata_nxt;
   end

   assign reg_bus.reg_rdata_o = rdata;

   assign riscv_bp0_bp_en_o     = bp0[0];
   assign riscv_bp0_bp_addr_o   = bp0[31:1];
   assign riscv_bp1_bp_en_o     = bp1[0];
   assign riscv_bp1_bp_addr_o   = bp1[31:1];
   assign riscv_dbp0_dbp_en_o   = dbp0[0];
   assign riscv_dbp0_dbp_wr_o   = dbp0[1];
   assign riscv_dbp0_dbp_addr_o = dbp0[31:2];
   assign riscv_dbp1_dbp_en_o   = dbp1[0];
   assign riscv_dbp1_dbp_wr_o   = dbp1[1];
   assign riscv_dbp1_dbp_addr_o = dbp1[31:2];

endmodule

// File: doc/iot_riscv_dbgctrl.md
IOT_RISCV_DBGCTRL -- requirements
Module: iot_riscv_dbgctrl

Interface
REQ-001 Parameters: none.
REQ-002 main_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 main_rst_an_i  in  1  reset, asynchronous, active-low.
REQ-004 reg_en_i  in  1  register access strobe, one access per cycle.
REQ-005 reg_wr_i  in  1  1=write, 0=read; qualified by reg_en_i.
REQ-006 reg_addr_i  in  3  word index: 0 CTRL, 1 STATUS, 2 BP0, 3 BP1, 4 DBP0, 5 DBP1, 6 HALTCNT, 7 reserved.
REQ-007 reg_wdata_i  in  32  write data.
REQ-008 reg_rdata_o  out  32  registered read data.
REQ-009 riscv_debug_pause_o  out  1  pause request to core debug unit.
REQ-010 riscv_debug_step_o  out  1  step/release pulse to core debug unit.
REQ-011 debug_halt_i  in  1  core instruction-halt state.
REQ-012 debug_halt_data_i  in  1  core data-breakpoint halt state.
REQ-013 riscv_debug_break_i  in  1  ebreak indication from core.
REQ-014 riscv_bp0_bp_addr_o  out  31  BP0 instruction address [31:1].
REQ-015 riscv_bp0_bp_en_o  out  1  BP0 enable.
REQ-016 riscv_bp1_bp_addr_o  out  31  BP1 instruction address [31:1].
REQ-017 riscv_bp1_bp_en_o  out  1  BP1 enable.
REQ-018 riscv_dbp0_dbp_en_o / riscv_dbp0_dbp_wr_o  out  1/1  DBP0 enable / 1=write match, 0=read match.
REQ-019 riscv_dbp0_dbp_addr_o  out  30  DBP0 data address [31:2].
REQ-020 riscv_dbp1_dbp_en_o / riscv_dbp1_dbp_wr_o / riscv_dbp1_dbp_addr_o  out  1/1/30  same for DBP1.

Function
REQ-021 Register fields SHALL be: BP0/BP1 bit0 en, [31:1] addr; DBP0/DBP1 bit0 en, bit1 wr, [31:2] addr; writes take effect on outputs the next cycle; reads return stored values.
REQ-022 CTRL SHALL be write-1 commands (bit0 HALT, bit1 STEP, bit2 RESUME, bit3 CLR_BRK), reading 0; priority RESUME > STEP > HALT; commands invalid in current state ignored.
REQ-023 Reads SHALL return data on reg_rdata_o one cycle after reg_en_i&~reg_wr_i; rdata holds otherwise; reserved address reads 0, writes ignored.
REQ-024 FSM states SHALL be RUN=0, PAUSING=1, HALTED=2, STEP=3, STEPWAIT=4, RESUME=5.
REQ-025 RUN: HALT -> PAUSING with pause_o=1; debug_halt_i=1 or debug_halt_data_i=1 -> HALTED with pause_o=1 set same edge.
REQ-026 PAUSING: debug_halt_i=1 -> HALTED.
REQ-027 HALTED: STEP -> STEP; RESUME -> RESUME; pause_o held 1.
REQ-028 STEP: step_o=1 for exactly one cycle, pause_o=1, then STEPWAIT unconditionally.
REQ-029 STEPWAIT: step_o=0; debug_halt_i=1 -> HALTED.
REQ-030 RESUME: pause_o=0 and step_o=1 for exactly one cycle, then RUN.
REQ-031 step_o SHALL never be asserted outside STEP/RESUME nor for two consecutive cycles.
REQ-032 STATUS SHALL read [2:0] state, bit3 debug_halt_i, bit4 debug_halt_data_i, bit5 sticky BRK.
REQ-033 BRK SHALL set on riscv_debug_break_i=1, clear on CLR_BRK; simultaneous set and clear: set wins.

Reset
REQ-034 On main_rst_an_i=0: state RUN, pause_o=0, step_o=0, all BP/DBP outputs 0, BRK=0, HALTCNT=0, reg_rdata_o=0, regardless of operation in progress.
REQ-035 After reset release, first register access SHALL be accepted in the first clock cycle.

Configuration
REQ-036 Macro IOT_RISCV_DBGCTRL_HALTCNT_EN defined: HALTCNT counts cycles with debug_halt_i=1, saturating at 0xFFFFFFFF, any write clears to 0 (write wins over increment).
REQ-037 Macro undefined: no counter flops; HALTCNT reads 0, writes ignored; all else identical.

Verification
REQ-038 Write CTRL=0x1 in RUN, drive debug_halt_i=1 two cycles later -> pause_o=1 next cycle, STATUS[2:0]=1 then 2.
REQ-039 In HALTED write CTRL=0x2 -> step_o=1 one cycle with pause_o=1, STATUS=4, debug_halt_i 0->1 returns STATUS=2.
REQ-040 In HALTED write CTRL=0x6 -> RESUME taken: pause_o=0, one-cycle step_o=1, STATUS=0.
REQ-041 Write BP0=0x00001001, DBP1=0x00002003 -> bp0_en=1, bp0_addr=0x800, dbp1_en=1, dbp1_wr=1, dbp1_addr=0x800; readback matches.
REQ-042 break_i=1 same cycle as CLR_BRK write -> STATUS bit5=1; later CLR_BRK alone -> bit5=0.
REQ-043 Macro on: 10 cycles halted -> HALTCNT=10; write HALTCNT -> 0; reset asserted in STEP -> step_o=0, pause_o=0, STATUS=0.
